// File: rtl/mips_issue.sv
// mips_issue: MIPS decode / operand-issue stage feeding a single-cycle-registered ALU.
// Latency: an instruction accepted at edge N presents its bundle (alu_valid=1) during cycle N+1.
// Backpressure: inst_ready drops while a used source register is pending; no output backpressure.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset (0 = reset)
//   inst_valid/inst     32-bit instruction word in, valid/ready handshake
//   inst_ready          stage can accept inst this cycle
//   wb_en/addr/data     write-back port from the ALU/memory side
//   alu_valid           one-cycle pulse per issued instruction
//   opcode, rrs, rrt, imm, funct, shamt, dst_en, dst   issued bundle, held between issues
//   err_illegal         sticky unsupported-instruction flag, cleared only by reset
//
// Optional build macro ISSUE_BYPASS_EN: a write-back in the current cycle resolves a pending
// source in that same cycle, and rrs/rrt take wb_data on an address match.
// Without the macro, stall is evaluated only against the registered pending bits.
module mips_issue #(
  parameter int          NREG    = 32,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        alu_valid,
  output logic [5:0]  opcode,
  output logic [31:0] rrs,
  output logic [31:0] rrt,
  output logic [15:0] imm,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  output logic        dst_en,
  output logic [4:0]  dst,
  output logic        err_illegal
);

  // Architectural state
  logic [31:0]     regs [NREG];
  logic [NREG-1:0] pend;

  // Instruction fields
  logic [5:0] op_c;
  logic [5:0] fn_c;
  logic [4:0] rs_c;
  logic [4:0] rt_c;
  logic [4:0] rd_c;

  assign op_c = inst[31:26];
  assign rs_c = inst[25:21];
  assign rt_c = inst[20:16];
  assign rd_c = inst[15:11];
  assign fn_c = inst[5:0];

  // Decode results
  logic       legal;
  logic       use_rs;
  logic       use_rt;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic       dst_en_c;

  always_comb begin
    legal  = 1'b0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    wr_en  = 1'b0;
    wr_idx = 5'd0;
    case (op_c)
      6'h00: begin
        case (fn_c)
          // Register-register ALU ops and variable shifts read both sources
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07: begin
            legal  = 1'b1;
            use_rs = 1'b1;
            use_rt = 1'b1;
          end
          // Shift-by-immediate: the rs field is don't-care, so it must not stall
          6'h00, 6'h02, 6'h03: begin
            legal  = 1'b1;
            use_rt = 1'b1;
          end
          default: begin
            legal = 1'b0;
          end
        endcase
        wr_en  = legal;
        wr_idx = legal ? rd_c : 5'd0;
      end
      // I-type ALU ops and LW write rt
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23: begin
        legal  = 1'b1;
        use_rs = 1'b1;
        wr_en  = 1'b1;
        wr_idx = rt_c;
      end
      // SW: reads base and store data, writes nothing
      6'h2B: begin
        legal  = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Writing r0 is architecturally a no-op, so it never reserves the scoreboard
  assign dst_en_c = wr_en & (wr_idx != 5'd0);

  // Register read, r0 forced to zero
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  always_comb begin
    rs_val = (rs_c == 5'd0) ? 32'h0 : regs[rs_c];
    rt_val = (rt_c == 5'd0) ? 32'h0 : regs[rt_c];
`ifdef ISSUE_BYPASS_EN
    // Write-through: the value landing this edge is what the consumer must see
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs_c)) rs_val = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rt_c)) rt_val = wb_data;
`endif
  end

  // Hazard detection
  logic [NREG-1:0] pend_eff;
  logic            stall;

  always_comb begin
    pend_eff = pend;
`ifdef ISSUE_BYPASS_EN
    // A write-back arriving now resolves its register for this cycle's decision
    if (wb_en) pend_eff[wb_addr] = 1'b0;
`endif
    stall = (use_rs & pend_eff[rs_c]) | (use_rt & pend_eff[rt_c]);
  end

  logic accept;
  logic issue;

  assign inst_ready = rst & ~stall;
  assign accept     = inst_valid & inst_ready;
  // Illegal words are consumed but never issued
  assign issue      = accept & legal;

  // Scoreboard next state: clear on write-back, then set on issue so set wins
  logic [NREG-1:0] pend_nxt;

  always_comb begin
    pend_nxt = pend;
    if (wb_en) pend_nxt[wb_addr] = 1'b0;
    if (issue && dst_en_c) pend_nxt[wr_idx] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Register file; r0 holds RST_VAL but every read of it returns zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard, issue bundle and sticky error
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend        <= '0;
      alu_valid   <= 1'b0;
      opcode      <= 6'd0;
      rrs         <= 32'h0;
      rrt         <= 32'h0;
      imm         <= 16'h0;
      funct       <= 6'd0;
      shamt       <= 5'd0;
      dst_en      <= 1'b0;
      dst         <= 5'd0;
      err_illegal <= 1'b0;
    end else begin
      pend      <= pend_nxt;
      alu_valid <= issue;
      // Fields only move on issue so the consumer sees stable values between pulses
      if (issue) begin
        opcode <= op_c;
        rrs    <= rs_val;
        rrt    <= rt_val;
        imm    <= inst[15:0];
        funct  <= fn_c;
        shamt  <= inst[10:6];
        dst_en <= dst_en_c;
        dst    <= wr_idx;
      end
      if (accept && !legal) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_issue.sv
// tb_mips_issue: table-driven check of mips_issue with a scoreboard queue of issued bundles.
// Each vector is driven one cycle; inst_ready is compared before the edge, outputs after it.
// Built with or without ISSUE_BYPASS_EN; the table adapts the bypass-sensitive rows.
module tb_mips_issue;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        alu_valid;
  logic [5:0]  opcode;
  logic [31:0] rrs;
  logic [31:0] rrt;
  logic [15:0] imm;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        dst_en;
  logic [4:0]  dst;
  logic        err_illegal;

  mips_issue dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_ready  (inst_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .alu_valid   (alu_valid),
    .opcode      (opcode),
    .rrs         (rrs),
    .rrt         (rrt),
    .imm         (imm),
    .funct       (funct),
    .shamt       (shamt),
    .dst_en      (dst_en),
    .dst         (dst),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iv;
    logic [31:0] ins;
    logic        rdy;
    logic        iss;
    logic [31:0] rrs;
    logic [31:0] rrt;
    logic        den;
    logic [4:0]  dst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rrs;
    logic [31:0] rrt;
    logic [15:0] imm;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic        den;
    logic [4:0]  dst;
  } bun_t;

  vec_t vecs[$];
  bun_t exp_q[$];
  bun_t last;
  int   n_chk;
  int   n_fail;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [31:0] ins,
                              input logic rdy, input logic iss,
                              input logic [31:0] xs, input logic [31:0] xt,
                              input logic den, input logic [4:0] d, input logic err);
    vec_t v;
    v.wb_en = we;  v.wb_addr = wa; v.wb_data = wd;
    v.iv    = iv;  v.ins     = ins;
    v.rdy   = rdy; v.iss     = iss;
    v.rrs   = xs;  v.rrt     = xt;
    v.den   = den; v.dst     = d;  v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Compare the registered bundle against the scoreboard (or the held values when idle)
  task automatic check_out(input string tag, input logic exp_err);
    bun_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " alu_valid"}, {31'd0, alu_valid}, 32'd1);
      last = e;
    end else begin
      e = last;
      chk({tag, " alu_valid"}, {31'd0, alu_valid}, 32'd0);
    end
    chk({tag, " opcode"}, {26'd0, opcode}, {26'd0, e.op});
    chk({tag, " rrs"},    rrs, e.rrs);
    chk({tag, " rrt"},    rrt, e.rrt);
    chk({tag, " imm"},    {16'd0, imm}, {16'd0, e.imm});
    chk({tag, " funct"},  {26'd0, funct}, {26'd0, e.fn});
    chk({tag, " shamt"},  {27'd0, shamt}, {27'd0, e.sh});
    chk({tag, " dst_en"}, {31'd0, dst_en}, {31'd0, e.den});
    chk({tag, " dst"},    {27'd0, dst}, {27'd0, e.dst});
    chk({tag, " err_illegal"}, {31'd0, err_illegal}, {31'd0, exp_err});
  endtask

  task automatic apply(input vec_t v, input int idx);
    bun_t b;
    string tag;
    tag        = $sformatf("v%0d", idx);
    wb_en      = v.wb_en;
    wb_addr    = v.wb_addr;
    wb_data    = v.wb_data;
    inst_valid = v.iv;
    inst       = v.ins;
    #1;
    chk({tag, " inst_ready"}, {31'd0, inst_ready}, {31'd0, v.rdy});
    if (v.iss) begin
      b.op  = v.ins[31:26];
      b.rrs = v.rrs;
      b.rrt = v.rrt;
      b.imm = v.ins[15:0];
      b.fn  = v.ins[5:0];
      b.sh  = v.ins[10:6];
      b.den = v.den;
      b.dst = v.dst;
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    check_out(tag, v.err);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    last   = '{default: '0};

    // Reset with an instruction and a write-back presented: both must be discarded
    rst        = 1'b0;
    inst_valid = 1'b1;
    inst       = 32'h00221821;
    wb_en      = 1'b1;
    wb_addr    = 5'd1;
    wb_data    = 32'd99;
    @(posedge clk);
    #1;
    chk("reset inst_ready", {31'd0, inst_ready}, 32'd0);
    check_out("reset", 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //          wb_en addr data          iv  inst          rdy iss rrs           rrt           den dst err
    vecs.push_back(mk(0, 0,  0,            1, 32'h00206821, 1, 1, 32'd0,        32'd0,        1, 13, 0)); // r1 write in reset dropped
    vecs.push_back(mk(1, 1,  5,            0, 32'h0,        1, 0, 0,            0,            0, 0,  0));
    vecs.push_back(mk(1, 2,  7,            0, 32'h0,        1, 0, 0,            0,            0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            1, 32'h00221821, 1, 1, 32'd5,        32'd7,        1, 3,  0)); // ADDU r3,r1,r2
    vecs.push_back(mk(1, 3,  12,           1, 32'h2404FFFF, 1, 1, 32'd0,        32'd0,        1, 4,  0)); // ADDIU r4,r0,-1
    vecs.push_back(mk(0, 0,  0,            1, 32'h00842821, 0, 0, 0,            0,            0, 0,  0)); // ADDU r5,r4,r4 stalls
`ifdef ISSUE_BYPASS_EN
    vecs.push_back(mk(1, 4,  32'hFFFFFFFF, 1, 32'h00842821, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5,  0));
    vecs.push_back(mk(0, 0,  0,            0, 32'h0,        1, 0, 0,            0,            0, 0,  0));
`else
    vecs.push_back(mk(1, 4,  32'hFFFFFFFF, 1, 32'h00842821, 0, 0, 0,            0,            0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            1, 32'h00842821, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5,  0));
`endif
    vecs.push_back(mk(1, 7,  32'h80000001, 1, 32'h24210001, 1, 1, 32'd5,        32'd5,        1, 1,  0)); // ADDIU r1,r1,1
`ifdef ISSUE_BYPASS_EN
    vecs.push_back(mk(1, 1,  6,            1, 32'h00273100, 1, 1, 32'd6,        32'h80000001, 1, 6,  0)); // SLL r6,r7,4
`else
    vecs.push_back(mk(1, 1,  6,            1, 32'h00273100, 1, 1, 32'd5,        32'h80000001, 1, 6,  0)); // SLL r6,r7,4
`endif
    vecs.push_back(mk(0, 0,  0,            1, 32'h00220021, 1, 1, 32'd6,        32'd7,        0, 0,  0)); // ADDU r0,r1,r2
    vecs.push_back(mk(1, 0,  9,            1, 32'h00004021, 1, 1, 32'd0,        32'd0,        1, 8,  0)); // ADDU r8,r0,r0 + wb r0
    vecs.push_back(mk(0, 0,  0,            1, 32'h00005021, 1, 1, 32'd0,        32'd0,        1, 10, 0)); // r0 still zero
    vecs.push_back(mk(0, 0,  0,            1, 32'hFC000000, 1, 0, 0,            0,            0, 0,  1)); // opcode 3F illegal
    vecs.push_back(mk(0, 0,  0,            1, 32'h344B00F0, 1, 1, 32'd7,        32'd0,        1, 11, 1)); // ORI r11,r2,F0
    vecs.push_back(mk(0, 0,  0,            1, 32'h0000003F, 1, 0, 0,            0,            0, 0,  1)); // R funct 3F illegal
    vecs.push_back(mk(0, 0,  0,            1, 32'hAC410004, 1, 1, 32'd7,        32'd6,        0, 0,  1)); // SW r1,4(r2)
`ifdef ISSUE_BYPASS_EN
    vecs.push_back(mk(1, 9,  1,            1, 32'h24090003, 1, 1, 32'd0,        32'd1,        1, 9,  1)); // ADDIU r9 + wb r9
`else
    vecs.push_back(mk(1, 9,  1,            1, 32'h24090003, 1, 1, 32'd0,        32'd0,        1, 9,  1)); // ADDIU r9 + wb r9
`endif
    vecs.push_back(mk(0, 0,  0,            1, 32'h01206021, 0, 0, 0,            0,            0, 0,  1)); // r9 pending: set won

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset while the dependent instruction is stalled
    rst        = 1'b0;
    inst_valid = 1'b1;
    inst       = 32'h01206021;
    wb_en      = 1'b0;
    #1;
    chk("midreset inst_ready", {31'd0, inst_ready}, 32'd0);
    @(posedge clk);
    #1;
    last = '{default: '0};
    check_out("midreset", 1'b0);
    rst = 1'b1;
    // Re-presented instruction issues at once: pending cleared, r9 back to reset value
    apply(mk(0, 0, 0, 1, 32'h01206021, 1, 1, 32'd0, 32'd0, 1, 12, 0), 99);
    apply(mk(0, 0, 0, 0, 32'h0,        1, 0, 0,     0,     0, 0,  0), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
